// File: rtl/fighter_pkg.sv
// Shared fighter definitions: attack type codes, phase codes and attack FSM state encoding.
package fighter_pkg;

   localparam int unsigned FRAME_W = 6;
   localparam int unsigned TYPE_W  = 2;
   localparam int unsigned PHASE_W = 2;

   localparam logic [TYPE_W-1:0] ATK_NONE  = 2'd0;
   localparam logic [TYPE_W-1:0] ATK_LIGHT = 2'd1;
   localparam logic [TYPE_W-1:0] ATK_HEAVY = 2'd2;

   localparam logic [PHASE_W-1:0] PH_IDLE     = 2'd0;
   localparam logic [PHASE_W-1:0] PH_STARTUP  = 2'd1;
   localparam logic [PHASE_W-1:0] PH_ACTIVE   = 2'd2;
   localparam logic [PHASE_W-1:0] PH_RECOVERY = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_STARTUP,
      ST_ACTIVE,
      ST_RECOVERY,
      ST_COOLDOWN
   } atk_state_t;

   // Phase code reported to the animation block; cooldown looks idle.
   function automatic logic [PHASE_W-1:0] phase_of(input atk_state_t s);
      case (s)
         ST_STARTUP:  return PH_STARTUP;
         ST_ACTIVE:   return PH_ACTIVE;
         ST_RECOVERY: return PH_RECOVERY;
         default:     return PH_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/btn_edge_latch.sv
// Button front end: 2-FF synchronizer, rising-edge detect, and a press latch
// that is dropped on every game frame so presses never carry across frames.
module btn_edge_latch (
   input  logic clk,
   input  logic reset,
   input  logic scen,
   input  logic btn,
   output logic pending_c
);

   logic sync1, sync2, prev, pending;
   logic rise_c;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         prev    <= 1'b0;
         pending <= 1'b0;
      end else begin
         sync1   <= btn;
         sync2   <= sync1;
         prev    <= sync2;
         pending <= scen ? 1'b0 : pending_c;
      end
   end

   // An edge arriving on the frame clk itself still counts for that frame.
   assign rise_c    = sync2 & ~prev;
   assign pending_c = pending | rise_c;

endmodule

// File: rtl/player_attack_ctrl.sv
// Per-player attack sequencer: turns button presses into startup/active/recovery/
// cooldown sequences stepped once per game frame, with hitstun cancel and one hit per attack.
module player_attack_ctrl
   import fighter_pkg::*;
#(
   parameter int unsigned ATK1_STARTUP  = 3,
   parameter int unsigned ATK1_ACTIVE   = 2,
   parameter int unsigned ATK1_RECOVERY = 6,
   parameter int unsigned ATK2_STARTUP  = 6,
   parameter int unsigned ATK2_ACTIVE   = 3,
   parameter int unsigned ATK2_RECOVERY = 10,
   parameter int unsigned COOLDOWN      = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               SCEN,
   input  logic               btn_atk1,
   input  logic               btn_atk2,
   input  logic               hitstun_active,
   input  logic               hit_landed,
   output logic               attack_active,
   output logic [TYPE_W-1:0]  attack_type,
   output logic [FRAME_W-1:0] attack_frame,
   output logic [PHASE_W-1:0] attack_phase,
   output logic               hitbox_active
);

   localparam int unsigned CNT_W = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN);
   localparam logic [CNT_W-1:0] CD_LAST = CNT_W'(COOLDOWN - 1);

   // Cumulative phase boundaries per attack type.
   localparam logic [FRAME_W-1:0] L1_ACT  = FRAME_W'(ATK1_STARTUP);
   localparam logic [FRAME_W-1:0] L1_REC  = FRAME_W'(ATK1_STARTUP + ATK1_ACTIVE);
   localparam logic [FRAME_W-1:0] L1_LAST = FRAME_W'(ATK1_STARTUP + ATK1_ACTIVE + ATK1_RECOVERY - 1);
   localparam logic [FRAME_W-1:0] L2_ACT  = FRAME_W'(ATK2_STARTUP);
   localparam logic [FRAME_W-1:0] L2_REC  = FRAME_W'(ATK2_STARTUP + ATK2_ACTIVE);
   localparam logic [FRAME_W-1:0] L2_LAST = FRAME_W'(ATK2_STARTUP + ATK2_ACTIVE + ATK2_RECOVERY - 1);

   localparam atk_state_t POST_ATK = (COOLDOWN == 0) ? ST_IDLE : ST_COOLDOWN;

   atk_state_t          state_q;
   logic [CNT_W-1:0]    cd_cnt;
   logic                hit_done;

   logic                pend1_c, pend2_c;
   logic                start_c, hit_set_c;
   logic [FRAME_W-1:0]  act_start_c, rec_start_c, last_c, frame_inc_c;
   atk_state_t          adv_state_c;

   btn_edge_latch u_btn1 (
      .clk       (clk),
      .reset     (reset),
      .scen      (SCEN),
      .btn       (btn_atk1),
      .pending_c (pend1_c)
   );

   btn_edge_latch u_btn2 (
      .clk       (clk),
      .reset     (reset),
      .scen      (SCEN),
      .btn       (btn_atk2),
      .pending_c (pend2_c)
   );

   // Phase the attack lands in after one more frame.
   always_comb begin
      act_start_c = (attack_type == ATK_HEAVY) ? L2_ACT  : L1_ACT;
      rec_start_c = (attack_type == ATK_HEAVY) ? L2_REC  : L1_REC;
      last_c      = (attack_type == ATK_HEAVY) ? L2_LAST : L1_LAST;
      frame_inc_c = attack_frame + FRAME_W'(1);
      if (frame_inc_c < act_start_c)
         adv_state_c = ST_STARTUP;
      else if (frame_inc_c < rec_start_c)
         adv_state_c = ST_ACTIVE;
      else
         adv_state_c = ST_RECOVERY;
   end

   assign start_c   = !hitstun_active && (pend1_c || pend2_c);
   assign hit_set_c = hit_landed && (state_q == ST_ACTIVE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         cd_cnt        <= '0;
         hit_done      <= 1'b0;
         attack_active <= 1'b0;
         attack_type   <= ATK_NONE;
         attack_frame  <= '0;
         attack_phase  <= PH_IDLE;
         hitbox_active <= 1'b0;
      end else begin
         // A connecting hit kills the hitbox on the next clk, frame or not.
         if (hit_set_c) begin
            hit_done      <= 1'b1;
            hitbox_active <= 1'b0;
         end
         if (SCEN) begin
            case (state_q)
               ST_IDLE: begin
                  if (start_c) begin
                     state_q       <= ST_STARTUP;
                     hit_done      <= 1'b0;
                     attack_active <= 1'b1;
                     attack_type   <= pend1_c ? ATK_LIGHT : ATK_HEAVY;
                     attack_frame  <= '0;
                     attack_phase  <= PH_STARTUP;
                     hitbox_active <= 1'b0;
                  end
               end
               ST_STARTUP, ST_ACTIVE, ST_RECOVERY: begin
                  if (hitstun_active || (attack_frame == last_c)) begin
                     state_q       <= POST_ATK;
                     cd_cnt        <= '0;
                     attack_active <= 1'b0;
                     attack_type   <= ATK_NONE;
                     attack_frame  <= '0;
                     attack_phase  <= PH_IDLE;
                     hitbox_active <= 1'b0;
                  end else begin
                     state_q       <= adv_state_c;
                     attack_frame  <= frame_inc_c;
                     attack_phase  <= phase_of(adv_state_c);
                     hitbox_active <= (adv_state_c == ST_ACTIVE) && !(hit_done || hit_set_c);
                  end
               end
               ST_COOLDOWN: begin
                  // Hitstun freezes the cooldown count where it is.
                  if (!hitstun_active) begin
                     if (cd_cnt == CD_LAST)
                        state_q <= ST_IDLE;
                     else
                        cd_cnt <= cd_cnt + CNT_W'(1);
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_player_attack_ctrl.sv
// Scoreboard bench for player_attack_ctrl: a frame-level reference model pushes expected
// outputs per game frame / hit pulse, and a monitor pops and compares them.
module tb_player_attack_ctrl;

   localparam int S1 = 3, A1 = 2, R1 = 6;
   localparam int S2 = 6, A2 = 3, R2 = 10;
   localparam int CD = 4;

   typedef struct packed {
      logic       act;
      logic [1:0] typ;
      logic [5:0] frm;
      logic [1:0] ph;
      logic       hb;
   } exp_t;

   logic       clk, reset, SCEN, btn_atk1, btn_atk2, hitstun_active, hit_landed;
   logic       attack_active, hitbox_active;
   logic [1:0] attack_type, attack_phase;
   logic [5:0] attack_frame;

   player_attack_ctrl #(
      .ATK1_STARTUP(S1), .ATK1_ACTIVE(A1), .ATK1_RECOVERY(R1),
      .ATK2_STARTUP(S2), .ATK2_ACTIVE(A2), .ATK2_RECOVERY(R2),
      .COOLDOWN(CD)
   ) dut (
      .clk(clk), .reset(reset), .SCEN(SCEN),
      .btn_atk1(btn_atk1), .btn_atk2(btn_atk2),
      .hitstun_active(hitstun_active), .hit_landed(hit_landed),
      .attack_active(attack_active), .attack_type(attack_type),
      .attack_frame(attack_frame), .attack_phase(attack_phase),
      .hitbox_active(hitbox_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   rst_req = 0;
   int   rst_seen = 0;
   bit   end_req = 0;
   bit   end_done = 0;
   bit   ev = 0;

   // Reference model: attack described by type, frame index, cooldown frames left, hit flag.
   bit m_in;
   int m_type, m_frame, m_cd;
   bit m_hit;

   function automatic int m_total(input int t);
      return (t == 2) ? (S2 + A2 + R2) : (S1 + A1 + R1);
   endfunction

   function automatic int m_phase();
      int s, a;
      if (!m_in) return 0;
      s = (m_type == 2) ? S2 : S1;
      a = (m_type == 2) ? A2 : A1;
      if (m_frame < s) return 1;
      if (m_frame < s + a) return 2;
      return 3;
   endfunction

   function automatic exp_t snapshot();
      exp_t e;
      int   p;
      p     = m_phase();
      e.act = m_in;
      e.typ = 2'(m_type);
      e.frm = 6'(m_frame);
      e.ph  = 2'(p);
      e.hb  = (p == 2) && !m_hit;
      return e;
   endfunction

   task automatic model_reset();
      m_in = 0; m_type = 0; m_frame = 0; m_cd = 0; m_hit = 0;
   endtask

   task automatic model_leave();
      m_in = 0; m_type = 0; m_frame = 0; m_cd = CD;
   endtask

   task automatic model_frame(input bit p1, input bit p2, input bit hs);
      if (m_in) begin
         if (hs || m_frame == m_total(m_type) - 1) model_leave();
         else m_frame++;
      end else if (m_cd > 0) begin
         if (!hs) m_cd--;
      end else if (!hs && (p1 || p2)) begin
         m_in = 1; m_type = p1 ? 1 : 2; m_frame = 0; m_hit = 0;
      end
   endtask

   // One game frame of len clks, starting at a negedge; press held 2 clks then released.
   task automatic run_frame(input bit p1, input bit p2, input bit hs, input int hit_at, input int len);
      btn_atk1 = p1; btn_atk2 = p2; hitstun_active = hs;
      for (int c = 0; c < len - 1; c++) begin
         @(negedge clk);
         hit_landed = 1'b0;
         if (c == 1) begin btn_atk1 = 1'b0; btn_atk2 = 1'b0; end
         if (c == hit_at) begin
            hit_landed = 1'b1;
            if (m_in && m_phase() == 2) m_hit = 1;
            exp_q.push_back(snapshot());
         end
      end
      @(negedge clk);
      hit_landed = 1'b0;
      SCEN = 1'b1;
      model_frame(p1, p2, hs);
      exp_q.push_back(snapshot());
      @(negedge clk);
      SCEN = 1'b0;
   endtask

   // Monitor: outputs are presented on the clk after a frame strobe or hit pulse.
   always @(posedge clk) ev <= SCEN | hit_landed;

   always @(negedge clk) begin
      exp_t got, e;
      got = '{attack_active, attack_type, attack_frame, attack_phase, hitbox_active};
      if (rst_req != rst_seen) begin
         rst_seen = rst_req;
         checks++;
         if (got !== exp_t'(0)) begin
            errors++;
            $display("FAIL reset_outputs t=%0t got act=%0b type=%0d frame=%0d phase=%0d hb=%0b, want all 0",
                     $time, got.act, got.typ, got.frm, got.ph, got.hb);
         end
      end else if (ev && !reset) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL no_expectation t=%0t got act=%0b type=%0d frame=%0d", $time, got.act, got.typ, got.frm);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               errors++;
               $display("FAIL outputs t=%0t got act=%0b type=%0d frame=%0d phase=%0d hb=%0b, want act=%0b type=%0d frame=%0d phase=%0d hb=%0b",
                        $time, got.act, got.typ, got.frm, got.ph, got.hb, e.act, e.typ, e.frm, e.ph, e.hb);
            end
         end
      end
      if (end_req && !end_done) begin
         checks++;
         if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending, want 0", exp_q.size());
         end
         end_done = 1'b1;
      end
   end

   initial begin
      bit hit_used;
      int len, h;
      reset = 1'b1; SCEN = 1'b0; btn_atk1 = 1'b0; btn_atk2 = 1'b0;
      hitstun_active = 1'b0; hit_landed = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst_req++;
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Light attack, frames 0..10, then cooldown and idle
      run_frame(1, 0, 0, -1, 4);
      repeat (16) run_frame(0, 0, 0, -1, 4);

      // Both buttons -> light; heavy during recovery and during cooldown ignored
      run_frame(1, 1, 0, -1, 5);
      for (int i = 0; i < 16; i++) run_frame(0, (i == 7 || i == 12), 0, -1, 5);

      // Heavy with a hit at frame 6, then a clean heavy
      hit_used = 0;
      run_frame(0, 1, 0, -1, 6);
      repeat (30) begin
         h = (!hit_used && m_in && m_type == 2 && m_frame == 6) ? 1 : -1;
         if (h >= 0) hit_used = 1;
         run_frame(0, 0, 0, h, 6);
      end
      run_frame(0, 1, 0, -1, 6);
      repeat (24) run_frame(0, 0, 0, -1, 6);

      // Hitstun at light frame 4, frozen cooldown, press blocked by hitstun in idle
      run_frame(1, 0, 0, -1, 4);
      repeat (4) run_frame(0, 0, 0, -1, 4);
      run_frame(0, 0, 1, -1, 4);
      run_frame(1, 0, 1, -1, 4);
      run_frame(0, 0, 1, -1, 4);
      repeat (4) run_frame(0, 0, 0, -1, 4);
      run_frame(1, 0, 1, -1, 4);
      run_frame(0, 0, 0, -1, 4);

      // Long gap between frames: one start, no extra start on the next frame
      run_frame(1, 0, 0, -1, 20);
      run_frame(0, 0, 0, -1, 4);
      repeat (16) run_frame(0, 0, 0, -1, 4);

      // Randomized frames
      repeat (300) begin
         len = $urandom_range(4, 8);
         h   = ($urandom % 3 == 0) ? int'($urandom_range(0, len - 2)) : -1;
         run_frame(($urandom % 4 == 0), ($urandom % 4 == 0), ($urandom % 8 == 0), h, len);
      end

      // Reset at heavy frame 7
      repeat (20) run_frame(0, 0, 0, -1, 4);
      run_frame(0, 1, 0, -1, 4);
      repeat (7) run_frame(0, 0, 0, -1, 4);
      @(posedge clk);
      #1 reset = 1'b1;
      rst_req++;
      model_reset();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (3) run_frame(0, 0, 0, -1, 4);
      run_frame(0, 1, 0, -1, 4);
      repeat (4) run_frame(0, 0, 0, -1, 4);

      end_req = 1'b1;
      for (int i = 0; i < 10 && !end_done; i++) @(negedge clk);
      if (!end_done) begin
         $display("FAIL monitor_timeout end check not reached");
         $fatal(1, "monitor did not respond");
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
